// File: rtl/mux_pipe_stage.sv
// Registered N:1 selector with a 2-entry skid buffer and valid/ready handshakes on both sides.
// Optional macro MUX_PIPE_STAGE_ERR_CNT_EN adds a saturating out-of-range-select counter (err_cnt).
module mux_pipe_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_PIPE_STAGE_ERR_CNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    // Handshake: a beat moves on a clk edge where valid && ready are both high.
    // The producer holds its beat stable until it moves; ready never depends
    // combinationally on the opposite side's valid or ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d;
    logic               head_err_q, head_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_err_q, skid_err_d;
    logic               in_ready_q, in_ready_d;

    logic [SEL_W:0]     sel_ext;
    logic               sel_oor;
    logic [WIDTH-1:0]   cap_data;
    logic               accept;
    logic               consume;

    // One extra index bit so out-of-range detection cannot wrap.
    assign sel_ext = {1'b0, sel};
    assign sel_oor = (sel_ext >= (SEL_W+1)'(NUM_IN));

    always_comb begin
        cap_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_ext == (SEL_W+1)'(k)) begin
                cap_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept    = in_valid && in_ready_q;
    assign consume   = (state_q != ST_EMPTY) && out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_data_q;
    assign out_err   = head_err_q;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_data_d = cap_data;
                    head_err_d  = sel_oor;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    head_data_d = cap_data;
                    head_err_d  = sel_oor;
                end else if (accept) begin
                    skid_data_d = cap_data;
                    skid_err_d  = sel_oor;
                    state_d     = ST_FULL;
                end else if (consume) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    head_data_d = skid_data_q;
                    head_err_d  = skid_err_q;
                    skid_data_d = '0;
                    skid_err_d  = 1'b0;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef MUX_PIPE_STAGE_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && sel_oor && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
